lcd_ctrl_gen2: RTL and testbench
================================

// Module: lcd_ctrl_gen2
// PURPOSE
//  Parametrised successor of the 8x8 LCD image controller. Loads a W x H image from IROM into a
//  local buffer, applies host commands to a 2x2 operation window, and on WRITE streams the buffer to
//  IRB. Sits between the host command port (cmd/cmd_valid/busy) and the IROM/IRB macros. Adds MAX,
//  MIN and ROTATE commands, and supports repeated WRITE passes.
// PARAMETERS
//  IMG_W  8  image width in pixels, power of 2, >=4
//  IMG_H  8  image height in pixels, power of 2, >=4
//  DW     8  pixel width in bits
//  AW     $clog2(IMG_W*IMG_H)  derived address width; not overridden
// PORTS
//  clk        in   1    single clock; all logic on posedge
//  reset      in   1    synchronous, active-high reset
//  cmd        in   4    command opcode; sampled when cmd_valid=1 and busy=0
//  cmd_valid  in   1    command strobe
//  IROM_Q     in   DW   IROM read data; valid 1 cycle after the address is presented with IROM_EN=0
//  IROM_EN    out  1    IROM chip enable, active-low
//  IROM_A     out  AW   IROM address = y*IMG_W + x
//  IRB_RW     out  1    IRB write enable, active-low (0 = write)
//  IRB_D      out  DW   IRB write data
//  IRB_A      out  AW   IRB address
//  busy       out  1    1 = command not accepted this cycle
//  done       out  1    1-cycle pulse after the last IRB write of a WRITE pass
// BEHAVIOUR
//  Reset values: IROM_EN=1, IROM_A=0, IRB_RW=1, IRB_D=0, IRB_A=0, busy=1, done=0, state=LOAD,
//  window point (px,py)=(IMG_W/2, IMG_H/2).
//  Reset asserted mid-operation aborts the operation and restarts LOAD; buffer contents are don't-care.
//  Window: columns px-1..px, rows py-1..py; px in 1..IMG_W-1, py in 1..IMG_H-1.
//   Cells: a=(px-1,py-1), b=(px,py-1), c=(px-1,py), d=(px,py).
//  FSM:
//   LOAD: IROM_EN=0, IROM_A counts 0..N-1 (N=IMG_W*IMG_H); Q captured 1 cycle late into buf[A-1].
//    Takes N+1 cycles, then goes to IDLE.
//   IDLE: busy=0. On cmd_valid, latch cmd; busy=1 next cycle; go to EXEC (or WRITE for cmd 0).
//   EXEC: one cycle; updates buffer/point; returns to IDLE, so busy is high for exactly 1 cycle.
//   WRITE: IRB_RW=0, IRB_A=0..N-1, IRB_D=buf[IRB_A], one pixel per cycle (N cycles).
//    Next cycle: IRB_RW=1, done=1 for 1 cycle, then IDLE. Buffer is retained; later WRITEs are legal.
//  Opcodes:
//   0  WRITE
//   1  UP: py-1, clamps at 1
//   2  DOWN: py+1, clamps at IMG_H-1
//   3  LEFT: px-1, clamps at 1
//   4  RIGHT: px+1, clamps at IMG_W-1
//   5  MAX: all 4 cells = max
//   6  MIN: all 4 cells = min
//   7  AVG: all 4 cells = floor((a+b+c+d)/4), with a DW+2-bit sum
//   8  ROT_CCW: a<=b, b<=d, d<=c, c<=a
//   9  ROT_CW: a<=c, c<=d, d<=b, b<=a
//   10 MIRROR_X: swap rows (a<->c, b<->d)
//   11 MIRROR_Y: swap columns (a<->b, c<->d)
//   12-15 NOP: still take 1 busy cycle
//  cmd_valid while busy=1 is ignored; no queueing. A clamped shift is a NOP and does not error.
// STRUCTURE
//  lcd_ctrl_pkg: cmd_e opcode enum (4b), state_e {LOAD, IDLE, EXEC, WRITE}.
//  Sub-module lcd_win_alu: combinational; inputs a,b,c,d and op; outputs new a',b',c',d'.
//  Top holds the FSM, counters, the point register and the N x DW buffer.
// TESTING (default 8x8, DW=8; IROM pixel k = k)
//  Reset then LOAD -> busy falls at cycle 65 after reset release; WRITE -> IRB[k]==k for all k,
//   one done pulse.
//  AVG at (4,4) -> cells 27,28,35,36 all = floor(126/4) = 31; other cells unchanged.
//  RIGHT x5, DOWN x5, MAX -> point clamps at (7,7); cells 54,55,62,63 = 63.
//  ROT_CW at (4,4) -> IRB[27]=35, IRB[28]=27, IRB[36]=28, IRB[35]=36.
//   ROT_CCW then restores the originals.
//  MIRROR_X, MIRROR_Y, MIN, opcode 13 (NOP), and cmd_valid held high while busy
//   -> exact expected images; busy is 1 cycle per op.
//  Reset during WRITE at pixel 20 -> LOAD restarts with no done pulse;
//   a second WRITE yields the original image.

Source files
------------

// File: rtl/lcd_ctrl_gen2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_ctrl_pkg
// Description : Shared types for the LCD image controller: host command
//               opcodes and the controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_ctrl_pkg;

    // Host opcodes. Values 12..15 are folded onto CMD_NOP when latched.
    typedef enum logic [3:0] {
        CMD_WRITE    = 4'd0,
        CMD_UP       = 4'd1,
        CMD_DOWN     = 4'd2,
        CMD_LEFT     = 4'd3,
        CMD_RIGHT    = 4'd4,
        CMD_MAX      = 4'd5,
        CMD_MIN      = 4'd6,
        CMD_AVG      = 4'd7,
        CMD_ROT_CCW  = 4'd8,
        CMD_ROT_CW   = 4'd9,
        CMD_MIRROR_X = 4'd10,
        CMD_MIRROR_Y = 4'd11,
        CMD_NOP      = 4'd12
    } cmd_e;

    localparam logic [3:0] c_CMD_LAST = 4'd11;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WRITE = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/lcd_ctrl_gen2_win_alu.sv
`default_nettype none
// ============================================================================
// Module      : lcd_win_alu
// Description : Combinational 2x2 window operator. Takes the four window
//               cells (a top-left, b top-right, c bottom-left, d bottom-right)
//               and an opcode, and returns the new cell values. Opcodes that
//               do not touch pixels pass the cells through unchanged.
// Ports       : i_a..i_d  current cells      (DW each)
//               i_op      latched opcode     (cmd_e)
//               o_a..o_d  updated cells      (DW each)
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_win_alu
    import lcd_ctrl_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    input  logic [DW-1:0] i_c,
    input  logic [DW-1:0] i_d,
    input  cmd_e          i_op,
    output logic [DW-1:0] o_a,
    output logic [DW-1:0] o_b,
    output logic [DW-1:0] o_c,
    output logic [DW-1:0] o_d
);

    logic [DW-1:0] w_max_ab;
    logic [DW-1:0] w_max_cd;
    logic [DW-1:0] w_max;
    logic [DW-1:0] w_min_ab;
    logic [DW-1:0] w_min_cd;
    logic [DW-1:0] w_min;
    logic [DW+1:0] w_sum;
    logic [DW-1:0] w_avg;

    assign w_max_ab = (i_a > i_b) ? i_a : i_b;
    assign w_max_cd = (i_c > i_d) ? i_c : i_d;
    assign w_max    = (w_max_ab > w_max_cd) ? w_max_ab : w_max_cd;
    assign w_min_ab = (i_a < i_b) ? i_a : i_b;
    assign w_min_cd = (i_c < i_d) ? i_c : i_d;
    assign w_min    = (w_min_ab < w_min_cd) ? w_min_ab : w_min_cd;

    // Two guard bits so four full-scale pixels cannot overflow the sum.
    assign w_sum = {2'b00, i_a} + {2'b00, i_b} + {2'b00, i_c} + {2'b00, i_d};
    assign w_avg = DW'(w_sum >> 2);

    always_comb begin
        o_a = i_a;
        o_b = i_b;
        o_c = i_c;
        o_d = i_d;
        case (i_op)
            CMD_MAX: begin
                o_a = w_max; o_b = w_max; o_c = w_max; o_d = w_max;
            end
            CMD_MIN: begin
                o_a = w_min; o_b = w_min; o_c = w_min; o_d = w_min;
            end
            CMD_AVG: begin
                o_a = w_avg; o_b = w_avg; o_c = w_avg; o_d = w_avg;
            end
            CMD_ROT_CCW: begin
                o_a = i_b; o_b = i_d; o_d = i_c; o_c = i_a;
            end
            CMD_ROT_CW: begin
                o_a = i_c; o_c = i_d; o_d = i_b; o_b = i_a;
            end
            CMD_MIRROR_X: begin
                o_a = i_c; o_c = i_a; o_b = i_d; o_d = i_b;
            end
            CMD_MIRROR_Y: begin
                o_a = i_b; o_b = i_a; o_c = i_d; o_d = i_c;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lcd_ctrl_gen2.sv
`default_nettype none
// ============================================================================
// Module      : lcd_ctrl_gen2
// Description : Parametrised LCD image controller. Loads an IMG_W x IMG_H
//               image from IROM into a local buffer, applies host commands to
//               a 2x2 window anchored at point (px,py), and streams the buffer
//               to IRB on WRITE. Repeated WRITE passes are allowed.
// Ports       : clk, reset          clock / synchronous active-high reset
//               cmd, cmd_valid      host command and strobe (taken when !busy)
//               IROM_Q              IROM read data
//               IROM_EN, IROM_A     IROM enable (active-low) and address
//               IRB_RW, IRB_D/A     IRB write enable (active-low), data, addr
//               busy                command not accepted this cycle
//               done                one-cycle pulse ending a WRITE pass
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_ctrl_gen2
    import lcd_ctrl_pkg::*;
#(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int DW    = 8,
    parameter int AW    = $clog2(IMG_W*IMG_H)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    cmd,
    input  logic          cmd_valid,
    input  logic [DW-1:0] IROM_Q,
    output logic          IROM_EN,
    output logic [AW-1:0] IROM_A,
    output logic          IRB_RW,
    output logic [DW-1:0] IRB_D,
    output logic [AW-1:0] IRB_A,
    output logic          busy,
    output logic          done
);

    localparam int             c_XW      = $clog2(IMG_W);
    localparam int             c_YW      = $clog2(IMG_H);
    localparam int             c_N       = IMG_W * IMG_H;
    localparam logic [AW:0]    c_CNT_END = (AW+1)'(c_N);
    localparam logic [AW:0]    c_CNT_ONE = (AW+1)'(1);
    localparam logic [c_XW-1:0] c_X_MIN  = c_XW'(1);
    localparam logic [c_XW-1:0] c_X_MAX  = c_XW'(IMG_W - 1);
    localparam logic [c_XW-1:0] c_X_MID  = c_XW'(IMG_W / 2);
    localparam logic [c_YW-1:0] c_Y_MIN  = c_YW'(1);
    localparam logic [c_YW-1:0] c_Y_MAX  = c_YW'(IMG_H - 1);
    localparam logic [c_YW-1:0] c_Y_MID  = c_YW'(IMG_H / 2);

    state_e          r_state;
    logic [AW:0]     r_cnt;
    cmd_e            r_cmd;
    logic [c_XW-1:0] r_px;
    logic [c_YW-1:0] r_py;
    logic [DW-1:0]   r_buf [c_N];

    logic [c_XW-1:0] w_xl;
    logic [c_YW-1:0] w_yt;
    logic [AW-1:0]   w_addr_a;
    logic [AW-1:0]   w_addr_b;
    logic [AW-1:0]   w_addr_c;
    logic [AW-1:0]   w_addr_d;
    logic [DW-1:0]   w_a_new;
    logic [DW-1:0]   w_b_new;
    logic [DW-1:0]   w_c_new;
    logic [DW-1:0]   w_d_new;

    // Dimensions are powers of two, so address y*IMG_W + x is just {y, x}.
    assign w_xl     = r_px - c_X_MIN;
    assign w_yt     = r_py - c_Y_MIN;
    assign w_addr_a = {w_yt, w_xl};
    assign w_addr_b = {w_yt, r_px};
    assign w_addr_c = {r_py, w_xl};
    assign w_addr_d = {r_py, r_px};

    lcd_win_alu #(
        .DW   (DW)
    ) u_win_alu (
        .i_a  (r_buf[w_addr_a]),
        .i_b  (r_buf[w_addr_b]),
        .i_c  (r_buf[w_addr_c]),
        .i_d  (r_buf[w_addr_d]),
        .i_op (r_cmd),
        .o_a  (w_a_new),
        .o_b  (w_b_new),
        .o_c  (w_c_new),
        .o_d  (w_d_new)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_LOAD;
            r_cnt   <= '0;
            r_cmd   <= CMD_NOP;
            r_px    <= c_X_MID;
            r_py    <= c_Y_MID;
            IROM_EN <= 1'b1;
            IROM_A  <= '0;
            IRB_RW  <= 1'b1;
            IRB_D   <= '0;
            IRB_A   <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_LOAD: begin
                    // Data for the address presented last cycle is valid now;
                    // IROM_A still holds that address at this edge.
                    if (!IROM_EN) begin
                        r_buf[IROM_A] <= IROM_Q;
                    end
                    if (r_cnt == c_CNT_END) begin
                        IROM_EN <= 1'b1;
                        r_cnt   <= '0;
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        IROM_EN <= 1'b0;
                        IROM_A  <= r_cnt[AW-1:0];
                        r_cnt   <= r_cnt + c_CNT_ONE;
                    end
                end

                ST_IDLE: begin
                    if (cmd_valid) begin
                        busy    <= 1'b1;
                        r_cnt   <= '0;
                        r_cmd   <= (cmd > c_CMD_LAST) ? CMD_NOP : cmd_e'(cmd);
                        r_state <= (cmd == 4'd0) ? ST_WRITE : ST_EXEC;
                    end
                end

                ST_EXEC: begin
                    // Non-pixel opcodes come back from the ALU unchanged, so
                    // writing all four cells every time is harmless.
                    r_buf[w_addr_a] <= w_a_new;
                    r_buf[w_addr_b] <= w_b_new;
                    r_buf[w_addr_c] <= w_c_new;
                    r_buf[w_addr_d] <= w_d_new;
                    case (r_cmd)
                        CMD_UP:    if (r_py != c_Y_MIN) r_py <= r_py - c_Y_MIN;
                        CMD_DOWN:  if (r_py != c_Y_MAX) r_py <= r_py + c_Y_MIN;
                        CMD_LEFT:  if (r_px != c_X_MIN) r_px <= r_px - c_X_MIN;
                        CMD_RIGHT: if (r_px != c_X_MAX) r_px <= r_px + c_X_MIN;
                        default: begin
                        end
                    endcase
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end

                ST_WRITE: begin
                    if (r_cnt == c_CNT_END) begin
                        IRB_RW  <= 1'b1;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        IRB_RW <= 1'b0;
                        IRB_A  <= r_cnt[AW-1:0];
                        IRB_D  <= r_buf[r_cnt[AW-1:0]];
                        r_cnt  <= r_cnt + c_CNT_ONE;
                    end
                end

                default: begin
                    r_state <= ST_LOAD;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lcd_ctrl_gen2.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_ctrl_gen2
// Description : Self-checking bench for lcd_ctrl_gen2 (8x8, DW=8). Table of
//               single-op vectors, hand-written multi-cycle sequences and a
//               randomized run against a behavioural image model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_ctrl_gen2;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int DW = 8;
    localparam int N  = W * H;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [3:0]    cmd = 4'd0;
    logic          cmd_valid = 1'b0;
    logic [DW-1:0] IROM_Q = '0;
    logic          IROM_EN;
    logic [AW-1:0] IROM_A;
    logic          IRB_RW;
    logic [DW-1:0] IRB_D;
    logic [AW-1:0] IRB_A;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    lcd_ctrl_gen2 #(.IMG_W(W), .IMG_H(H), .DW(DW)) dut (
        .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
        .IROM_Q(IROM_Q), .IROM_EN(IROM_EN), .IROM_A(IROM_A),
        .IRB_RW(IRB_RW), .IRB_D(IRB_D), .IRB_A(IRB_A),
        .busy(busy), .done(done)
    );

    // Environment: IROM, IRB capture, done counter
    logic [DW-1:0] rom_img [N];
    logic [DW-1:0] irb_mem [N];
    logic          irb_clr = 1'b0;
    int            irb_wr_cnt = 0;
    int            done_cnt = 0;

    always @(negedge clk) if (!IROM_EN) IROM_Q <= rom_img[IROM_A];

    always @(negedge clk) begin
        if (irb_clr) begin
            for (int k = 0; k < N; k++) irb_mem[k] <= 'x;
        end else if (!IRB_RW) begin
            irb_mem[IRB_A] <= IRB_D;
            irb_wr_cnt     <= irb_wr_cnt + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    // Checking
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic compare_image(input string name, input logic [DW-1:0] exp [N]);
        int bad = 0;
        int first = -1;
        for (int k = 0; k < N; k++) begin
            if (irb_mem[k] !== exp[k]) begin
                bad++;
                if (first < 0) first = k;
            end
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL %s: %0d pixels differ, first IRB[%0d] got %0h expected %0h",
                     name, bad, first, irb_mem[first], exp[first]);
        end
    endtask

    // Behavioural model: image array plus window point
    logic [DW-1:0] m_img [N];
    int            m_px;
    int            m_py;

    task automatic model_reset();
        for (int k = 0; k < N; k++) m_img[k] = rom_img[k];
        m_px = W / 2;
        m_py = H / 2;
    endtask

    task automatic model_apply(input int op);
        int ia, ib, ic, id, va, vb, vc, vd, r;
        ia = (m_py - 1) * W + (m_px - 1);
        ib = ia + 1;
        ic = ia + W;
        id = ic + 1;
        va = m_img[ia]; vb = m_img[ib]; vc = m_img[ic]; vd = m_img[id];
        case (op)
            1: if (m_py > 1)     m_py = m_py - 1;
            2: if (m_py < H - 1) m_py = m_py + 1;
            3: if (m_px > 1)     m_px = m_px - 1;
            4: if (m_px < W - 1) m_px = m_px + 1;
            5, 6, 7: begin
                if (op == 5) begin
                    r = va;
                    if (vb > r) r = vb;
                    if (vc > r) r = vc;
                    if (vd > r) r = vd;
                end else if (op == 6) begin
                    r = va;
                    if (vb < r) r = vb;
                    if (vc < r) r = vc;
                    if (vd < r) r = vd;
                end else begin
                    r = (va + vb + vc + vd) / 4;
                end
                m_img[ia] = DW'(r); m_img[ib] = DW'(r);
                m_img[ic] = DW'(r); m_img[id] = DW'(r);
            end
            8: begin
                m_img[ia] = DW'(vb); m_img[ib] = DW'(vd);
                m_img[id] = DW'(vc); m_img[ic] = DW'(va);
            end
            9: begin
                m_img[ia] = DW'(vc); m_img[ic] = DW'(vd);
                m_img[id] = DW'(vb); m_img[ib] = DW'(va);
            end
            10: begin
                m_img[ia] = DW'(vc); m_img[ic] = DW'(va);
                m_img[ib] = DW'(vd); m_img[id] = DW'(vb);
            end
            11: begin
                m_img[ia] = DW'(vb); m_img[ib] = DW'(va);
                m_img[ic] = DW'(vd); m_img[id] = DW'(vc);
            end
            default: begin
            end
        endcase
    endtask

    // Stimulus helpers
    task automatic wait_load();
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (busy && n < 200);
        check("load_cycles", n, N + 1);
        model_reset();
    endtask

    task automatic reset_and_load(input bit chk_rst);
        @(negedge clk);
        reset = 1'b1;
        cmd_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        if (chk_rst) begin
            check("rst_IROM_EN", IROM_EN, 1);
            check("rst_IROM_A", IROM_A, 0);
            check("rst_IRB_RW", IRB_RW, 1);
            check("rst_IRB_D", IRB_D, 0);
            check("rst_IRB_A", IRB_A, 0);
            check("rst_busy", busy, 1);
            check("rst_done", done, 0);
        end
        @(negedge clk);
        reset = 1'b0;
        wait_load();
    endtask

    task automatic issue_cmd(input logic [3:0] op);
        int t = 0;
        @(negedge clk);
        while (busy && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (busy) check("idle_timeout", 1, 0);
        cmd = op;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("busy_after_accept", busy, 1);
    endtask

    task automatic exec_cmd(input logic [3:0] op);
        issue_cmd(op);
        @(negedge clk);
        check("busy_one_cycle", busy, 0);
        model_apply(int'(op));
    endtask

    task automatic do_write(input string name, input logic [DW-1:0] exp [N]);
        int t = 0;
        int wr0, dn0;
        @(negedge clk);
        irb_clr = 1'b1;
        @(posedge clk);
        irb_clr = 1'b0;
        wr0 = irb_wr_cnt;
        dn0 = done_cnt;
        issue_cmd(4'd0);
        while (!done && t < N + 20) begin
            @(negedge clk);
            t++;
        end
        check("done_seen", int'(done), 1);
        t = 0;
        while (busy && t < 20) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        check("write_count", irb_wr_cnt - wr0, N);
        check("done_pulses", done_cnt - dn0, 1);
        compare_image(name, exp);
    endtask

    // Table of single-op vectors applied at the reset point (4,4) on image k=k.
    // Cells: a=27, b=28, c=35, d=36.
    typedef struct {
        logic [3:0] op;
        int ea;
        int eb;
        int ec;
        int ed;
    } vec_t;

    vec_t          vecs [10];
    logic [DW-1:0] e_img [N];

    task automatic set_identity();
        for (int k = 0; k < N; k++) rom_img[k] = DW'(k);
        for (int k = 0; k < N; k++) e_img[k] = DW'(k);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{4'd5,  36, 36, 36, 36};
        vecs[1] = '{4'd6,  27, 27, 27, 27};
        vecs[2] = '{4'd7,  31, 31, 31, 31};
        vecs[3] = '{4'd8,  28, 36, 27, 35};
        vecs[4] = '{4'd9,  35, 27, 36, 28};
        vecs[5] = '{4'd10, 35, 36, 27, 28};
        vecs[6] = '{4'd11, 28, 27, 36, 35};
        vecs[7] = '{4'd13, 27, 28, 35, 36};
        vecs[8] = '{4'd1,  27, 28, 35, 36};
        vecs[9] = '{4'd15, 27, 28, 35, 36};

        // Reset state, load timing, plain write of identity image
        set_identity();
        reset_and_load(1'b1);
        do_write("identity", e_img);

        // Single-op table
        for (int i = 0; i < 10; i++) begin
            set_identity();
            reset_and_load(1'b0);
            exec_cmd(vecs[i].op);
            e_img[27] = DW'(vecs[i].ea);
            e_img[28] = DW'(vecs[i].eb);
            e_img[35] = DW'(vecs[i].ec);
            e_img[36] = DW'(vecs[i].ed);
            do_write($sformatf("table_op%0d", vecs[i].op), e_img);
        end

        // Clamp at bottom-right corner then MAX
        set_identity();
        reset_and_load(1'b0);
        for (int i = 0; i < 5; i++) exec_cmd(4'd4);
        for (int i = 0; i < 5; i++) exec_cmd(4'd2);
        exec_cmd(4'd5);
        e_img[54] = 8'd63; e_img[55] = 8'd63; e_img[62] = 8'd63;
        do_write("clamp_max", e_img);

        // ROT_CW, write, ROT_CCW, write original (second WRITE on same buffer)
        set_identity();
        reset_and_load(1'b0);
        exec_cmd(4'd9);
        e_img[27] = 8'd35; e_img[28] = 8'd27; e_img[36] = 8'd28; e_img[35] = 8'd36;
        do_write("rot_cw", e_img);
        exec_cmd(4'd8);
        set_identity();
        do_write("rot_ccw_restore", e_img);

        // cmd_valid held through the busy cycle: exactly one RIGHT taken
        set_identity();
        reset_and_load(1'b0);
        @(negedge clk);
        cmd = 4'd4;
        cmd_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        check("held_busy_hi", busy, 1);
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        check("held_busy_lo", busy, 0);
        exec_cmd(4'd5);
        e_img[28] = 8'd37; e_img[29] = 8'd37; e_img[36] = 8'd37; e_img[37] = 8'd37;
        do_write("held_valid", e_img);

        // Reset during WRITE at pixel 20
        begin
            int t = 0;
            int dn0;
            set_identity();
            reset_and_load(1'b0);
            issue_cmd(4'd0);
            while (!(IRB_RW == 1'b0 && IRB_A == 6'd20) && t < 200) begin
                @(negedge clk);
                t++;
            end
            check("abort_at_px20", int'(IRB_A), 20);
            dn0 = done_cnt;
            reset = 1'b1;
            @(posedge clk); @(posedge clk);
            @(negedge clk);
            reset = 1'b0;
            wait_load();
            @(negedge clk);
            check("no_done_on_abort", done_cnt - dn0, 0);
            do_write("after_abort", e_img);
        end

        // Randomized run on a random image against the model
        for (int k = 0; k < N; k++) rom_img[k] = DW'($urandom_range(0, 255));
        reset_and_load(1'b0);
        for (int i = 0; i < 240; i++) begin
            exec_cmd(4'($urandom_range(1, 15)));
            if (i % 40 == 39) do_write($sformatf("random_%0d", i), m_img);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
